// File: rtl/comp_seq_ctrl.sv
// Sequences one shared 2-bit magnitude-comparator slice across two WIDTH-bit
// operands, MSB pair first, stopping at the first unequal pair.
module comp_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             eq,
  output logic             err,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             slice_l,
  input  logic             slice_g,
  input  logic             slice_eq
);

  localparam int PAIRS = WIDTH / 2;
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             l_reg;
  logic             g_reg;
  logic             eq_reg;
  logic             err_reg;

  // Latched operands viewed as an array of bit-pairs, index 0 = LSB pair.
  logic [1:0] a_pair [PAIRS];
  logic [1:0] b_pair [PAIRS];

  generate
    for (genvar gi = 0; gi < PAIRS; gi++) begin : g_pair
      assign a_pair[gi] = a_reg[2*gi +: 2];
      assign b_pair[gi] = b_reg[2*gi +: 2];
    end
  endgenerate

  assign slice_a = (state_reg == ST_RUN) ? a_pair[idx_reg] : 2'b00;
  assign slice_b = (state_reg == ST_RUN) ? b_pair[idx_reg] : 2'b00;

  logic [2:0] flags;
  assign flags = {slice_l, slice_g, slice_eq};

  assign busy = busy_reg;
  assign done = done_reg;
  assign l    = l_reg;
  assign g    = g_reg;
  assign eq   = eq_reg;
  assign err  = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      l_reg     <= 1'b0;
      g_reg     <= 1'b0;
      eq_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            idx_reg   <= IDX_W'(PAIRS - 1);
            l_reg     <= 1'b0;
            g_reg     <= 1'b0;
            eq_reg    <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Only a one-hot flag set is a legal slice answer; anything else
          // terminates the compare with err and no magnitude result.
          case (flags)
            3'b100: begin
              l_reg     <= 1'b1;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
            3'b010: begin
              g_reg     <= 1'b1;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
            3'b001: begin
              if (idx_reg == '0) begin
                eq_reg    <= 1'b1;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= ST_DONE;
              end else begin
                idx_reg <= idx_reg - IDX_W'(1);
              end
            end
            default: begin
              err_reg   <= 1'b1;
              l_reg     <= 1'b0;
              g_reg     <= 1'b0;
              eq_reg    <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          endcase
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Randomized bench for comp_seq_ctrl: a behavioural 2-bit comparator with
// fault injection feeds the DUT; results and latency come from integer math.
module tb_comp_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int PAIRS = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy, done, l, g, eq, err;
  logic [1:0]       slice_a, slice_b;
  logic             slice_l, slice_g, slice_eq;
  logic [1:0]       inj;   // 0 = honest slice, 1 = no flags, 2 = all flags

  int compared   = 0;
  int mismatched = 0;
  int txn        = 0;
  logic exp_l, exp_g, exp_eq, exp_err;

  always #5 clk = ~clk;

  assign slice_l  = (inj == 2'd1) ? 1'b0 : (inj == 2'd2) ? 1'b1 : (slice_a < slice_b);
  assign slice_g  = (inj == 2'd1) ? 1'b0 : (inj == 2'd2) ? 1'b1 : (slice_a > slice_b);
  assign slice_eq = (inj == 2'd1) ? 1'b0 : (inj == 2'd2) ? 1'b1 : (slice_a == slice_b);

  comp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .l(l), .g(g), .eq(eq), .err(err),
    .slice_a(slice_a), .slice_b(slice_b),
    .slice_l(slice_l), .slice_g(slice_g), .slice_eq(slice_eq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pair_of(input logic [WIDTH-1:0] v, input int p);
    return int'((v >> (2 * p)) & 3);
  endfunction

  // One full compare. Caller is 1 time unit after an edge; the task returns in
  // the done cycle so a following call exercises back-to-back starts.
  task automatic run_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input int inj_at, input logic [1:0] inj_kind, input bit ign);
    int k, nat_lat, exp_lat, lat;
    bit ok;
    k = 0;
    for (int p = PAIRS - 1; p >= 0; p--) begin
      if (pair_of(av, p) != pair_of(bv, p)) break;
      k++;
    end
    nat_lat = (k == PAIRS) ? PAIRS : k + 1;
    if (inj_at >= 0 && inj_at < nat_lat) begin
      exp_lat = inj_at + 1;
      exp_err = 1'b1; exp_l = 1'b0; exp_g = 1'b0; exp_eq = 1'b0;
    end else begin
      exp_lat = nat_lat;
      exp_err = 1'b0;
      exp_l   = (av < bv);
      exp_g   = (av > bv);
      exp_eq  = (av == bv);
    end

    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    lat = 0;
    ok  = 1'b1;
    while (1) begin
      chk("busy_run", busy, 1'b1);
      chk("done_run", done, 1'b0);
      chk("flags_run", {l, g, eq, err}, 4'b0000);
      if (lat < PAIRS) begin
        chk("slice_a", slice_a, pair_of(av, PAIRS - 1 - lat));
        chk("slice_b", slice_b, pair_of(bv, PAIRS - 1 - lat));
      end
      if (lat == inj_at) inj = inj_kind;
      if (ign && lat == 0) begin
        start = 1'b1; a = '0; b = '0;
      end
      step();
      inj = 2'd0;
      start = 1'b0;
      lat++;
      if (done === 1'b1) break;
      if (lat > PAIRS + 2) begin
        chk("timeout", lat, exp_lat);
        ok = 1'b0;
        break;
      end
    end
    if (ok) chk("latency", lat, exp_lat);
    chk("done", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("result", {l, g, eq, err}, {exp_l, exp_g, exp_eq, exp_err});
    chk("slice_idle", {slice_a, slice_b}, 4'b0000);
    $display("txn %0d a=%02h b=%02h inj_at=%0d lat=%0d l=%0b g=%0b eq=%0b err=%0b",
             txn, av, bv, inj_at, lat, l, g, eq, err);
    txn++;
  endtask

  // Abandon an in-flight compare with rst at E0+2.
  task automatic reset_abort(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {l, g, eq, err}, 4'b0000);
    chk("rst_slice", {slice_a, slice_b}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_done", done, 1'b0);
    end
    $display("txn %0d reset abort a=%02h b=%02h", txn, av, bv);
    txn++;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("gap_done", done, 1'b0);
      chk("gap_busy", busy, 1'b0);
      chk("gap_held", {l, g, eq, err}, {exp_l, exp_g, exp_eq, exp_err});
    end
  endtask

  initial begin
    logic [WIDTH-1:0] av, bv, hi_mask;
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; inj = 2'd0;
    step();
    step();
    chk("reset_state", {busy, done, l, g, eq, err}, 6'b000000);
    chk("reset_slice", {slice_a, slice_b}, 4'b0000);
    rst = 1'b0;
    step();

    run_cmp(8'hA5, 8'hA5, -1, 2'd0, 1'b0);
    idle_gap(1);
    run_cmp(8'h80, 8'h7F, -1, 2'd0, 1'b0);
    idle_gap(1);
    run_cmp(8'h34, 8'h38, -1, 2'd0, 1'b1);
    idle_gap(1);
    reset_abort(8'hA5, 8'hA5);
    run_cmp(8'hA5, 8'hA5, -1, 2'd0, 1'b0);
    idle_gap(1);
    run_cmp(8'hC3, 8'h3C, 0, 2'd1, 1'b0);
    run_cmp(8'h01, 8'h02, -1, 2'd0, 1'b0);
    idle_gap(2);

    for (int it = 0; it < 250; it++) begin
      av = WIDTH'($urandom);
      bv = WIDTH'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        n = $urandom_range(0, PAIRS);
        hi_mask = (n == 0) ? '0 : WIDTH'({WIDTH{1'b1}} << (WIDTH - 2 * n));
        bv = (av & hi_mask) | (bv & ~hi_mask);
      end
      if ($urandom_range(0, 19) == 0) begin
        reset_abort(av, bv);
      end else begin
        run_cmp(av, bv,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, PAIRS - 1)) : -1,
                2'($urandom_range(1, 2)),
                1'($urandom_range(0, 3) == 0));
        idle_gap($urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
